// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package control_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH,
        JAL
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // alu_op tells the decoder whether to force add/sub or look at funct fields
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_type(input logic [6:0] op);
        case (op)
            OP_SW:     return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-op decoder: forced add/sub, or funct3/funct7 decode for
// R-type and I-type instructions.
module alu_decoder
    import control_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op_code_5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // only R-type (op_code[5]=1) may select sub; addi ignores funct7
                    3'b000:  alu_control = (op_code_5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Moore control FSM for a multicycle RISC-V datapath (lw, sw, R, I, beq/bne, jal).
// Write enables are masked while reset is held so an aborted instruction commits nothing.
module control_fsm
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       IR_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       instr_done
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;
    logic       pc_write_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       done_raw;

    // only funct7[5] matters to this ISA subset
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = FETCH;
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        done_raw      = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_OP_ADD;
        case (state)
            FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                next_state   = DECODE;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op_code)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTER;
                    OP_ITYPE:     next_state = EXECUTEI;
                    OP_BRANCH:    next_state = BRANCH;
                    OP_JAL:       next_state = JAL;
                    default: begin
                        next_state = FETCH;
                        done_raw   = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                next_state = (op_code == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                result_src    = RES_MEMDATA;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            EXECUTER: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALU_OP_FUNCT;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_OP_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            BRANCH: begin
                // funct3[0] inverts the sense: beq takes on Zero, bne on !Zero
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_RS2;
                alu_op       = ALU_OP_SUB;
                pc_write_raw = Zero ^ funct3[0];
                done_raw     = 1'b1;
            end
            JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
                next_state   = ALUWB;
            end
            default: next_state = FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7[5]),
        .op_code_5   (op_code[5]),
        .alu_control (alu_control)
    );

    assign imm_src    = imm_type(op_code);
    assign pc_write   = pc_write_raw  & ~reset;
    assign mem_write  = mem_write_raw & ~reset;
    assign IR_write   = ir_write_raw  & ~reset;
    assign reg_write  = reg_write_raw & ~reset;
    assign instr_done = done_raw      & ~reset;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed instruction runs with literal
// expectations, then randomized traffic compared every cycle to a step-based model.
module tb_control_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;
    // pc_write, mem_write, IR_write, reg_write, instr_done positions in outs
    localparam logic [16:0] EN_MASK = 17'b10111_00000000000_1;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op_code;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       pc_write, adr_src, mem_write, IR_write, reg_write, instr_done;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [16:0] outs;

    int checks = 0;
    int errors = 0;
    int m_step = 0;
    bit m_valid = 1'b0;
    logic [16:0] obs [6];
    int pulses;

    control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .op_code     (op_code),
        .funct3      (funct3),
        .funct7      (funct7),
        .Zero        (Zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .IR_write    (IR_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .instr_done  (instr_done)
    );

    assign outs = {pc_write, adr_src, mem_write, IR_write, reg_write, result_src,
                   alu_src_a, alu_src_b, imm_src, alu_control, instr_done};

    always #5 clk = ~clk;

    function automatic int instrLatency(input logic [6:0] op);
        case (op)
            LW:                 return 5;
            SW, RT, IT, JL:     return 4;
            BR:                 return 3;
            default:            return 2;
        endcase
    endfunction

    function automatic logic [2:0] refAlu(input logic [2:0] f3, input logic f7b5, input logic op5);
        logic [2:0] tbl [8];
        tbl = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
        if (f3 == 3'b000 && op5 && f7b5) return 3'd1;
        return tbl[f3];
    endfunction

    // Expected outputs from the cycle index within the current instruction
    function automatic logic [16:0] expected(input int s, input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic z, input logic rst);
        bit isLw, isSw, isR, isI, isBr, isJal, usesRs1;
        int last;
        logic pcw, adr, memw, irw, regw, done;
        logic [1:0] res, srcA, srcB, imm;
        logic [2:0] alu;
        isLw = (op == LW); isSw = (op == SW); isR = (op == RT);
        isI = (op == IT); isBr = (op == BR); isJal = (op == JL);
        usesRs1 = isLw | isSw | isR | isI | isBr;
        last = instrLatency(op) - 1;
        pcw  = (s == 0) || (isJal && s == 2) || (isBr && s == 2 && (z ^ f3[0]));
        irw  = (s == 0);
        adr  = (isLw || isSw) && s == 3;
        memw = isSw && s == 3;
        regw = (isLw | isR | isI | isJal) && s == last;
        done = (s == last);
        res  = (s == 0) ? 2'd2 : (isLw && s == 4) ? 2'd1 : 2'd0;
        srcA = (s == 1) ? 2'd1 : (s == 2) ? (isJal ? 2'd1 : usesRs1 ? 2'd2 : 2'd0) : 2'd0;
        srcB = (s == 0) ? 2'd2 : (s == 1) ? 2'd1 :
               (s == 2) ? (isJal ? 2'd2 : (isLw | isSw | isI) ? 2'd1 : 2'd0) : 2'd0;
        alu  = (s == 2 && (isR || isI)) ? refAlu(f3, f7[5], op[5]) : (s == 2 && isBr) ? 3'd1 : 3'd0;
        imm  = isSw ? 2'd1 : isBr ? 2'd2 : isJal ? 2'd3 : 2'd0;
        if (rst) begin
            pcw = 1'b0; memw = 1'b0; irw = 1'b0; regw = 1'b0; done = 1'b0;
        end
        return {pcw, adr, memw, irw, regw, res, srcA, srcB, imm, alu, done};
    endfunction

    task automatic applyStimulus(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic z);
        reset = rst; op_code = op; funct3 = f3; funct7 = f7; Zero = z;
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Runs one instruction starting just after the edge into FETCH
    task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic z);
        applyStimulus(1'b0, op, f3, f7, z);
        pulses = 0;
        for (int s = 0; s < instrLatency(op); s++) begin
            @(negedge clk);
            obs[s] = outs;
            if (outs[0]) pulses++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_step = 0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                if (m_step >= instrLatency(op_code) - 1) m_step = 0;
                else m_step = m_step + 1;
            end
        end
    end

    initial begin
        logic [16:0] exp;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                exp = expected(m_step, op_code, funct3, funct7, Zero, reset);
                checks++;
                if (outs !== exp) begin
                    errors++;
                    $display("[TB] FAIL model_cycle step=%0d op=%b reset=%b actual=%h required=%h",
                             m_step, op_code, reset, outs, exp);
                end
            end
        end
    end

    initial begin
        logic [6:0] ops [7];
        ops = '{LW, SW, RT, IT, BR, JL, BAD};

        applyStimulus(1'b1, RT, 3'b000, 7'b0100000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_enables_c1", int'(outs & EN_MASK), 0);
        @(posedge clk);
        #1;
        checkOutput("reset_enables_c2", int'(outs & EN_MASK), 0);
        reset = 1'b0;

        runInstr(RT, 3'b000, 7'b0100000, 1'b0);
        checkOutput("r_fetch_irwrite", int'(obs[0][13]), 1);
        checkOutput("r_fetch_pcwrite", int'(obs[0][16]), 1);
        checkOutput("r_decode_srcab", int'(obs[1][9:6]), 4'b0101);
        checkOutput("r_exec_sub", int'(obs[2][3:1]), 1);
        checkOutput("r_aluwb_regwrite", int'(obs[3][12]), 1);
        checkOutput("r_aluwb_done", int'(obs[3][0]), 1);

        runInstr(LW, 3'b010, 7'b0000000, 1'b0);
        checkOutput("lw_memread_adrsrc", int'(obs[3][15]), 1);
        checkOutput("lw_memwb_resultsrc", int'(obs[4][11:10]), 1);
        checkOutput("lw_memwb_regwrite", int'(obs[4][12]), 1);
        checkOutput("lw_done_pulses", pulses, 1);

        runInstr(SW, 3'b010, 7'b0000000, 1'b0);
        checkOutput("sw_memwrite", int'(obs[3][14]), 1);
        checkOutput("sw_adrsrc", int'(obs[3][15]), 1);
        checkOutput("sw_immsrc", int'(obs[3][5:4]), 1);
        checkOutput("sw_done_pulses", pulses, 1);

        runInstr(BR, 3'b000, 7'b0000000, 1'b1);
        checkOutput("beq_taken_pcwrite", int'(obs[2][16]), 1);
        runInstr(BR, 3'b001, 7'b0000000, 1'b1);
        checkOutput("bne_nottaken_pcwrite", int'(obs[2][16]), 0);

        runInstr(JL, 3'b000, 7'b0000000, 1'b0);
        checkOutput("jal_pcwrite", int'(obs[2][16]), 1);
        checkOutput("jal_srca", int'(obs[2][9:8]), 1);
        checkOutput("jal_srcb", int'(obs[2][7:6]), 2);
        checkOutput("jal_aluwb_regwrite", int'(obs[3][12]), 1);
        for (int s = 0; s < 4; s++) checkOutput("jal_immsrc", int'(obs[s][5:4]), 3);

        runInstr(BAD, 3'b000, 7'b0000000, 1'b0);
        checkOutput("nop_decode_done", int'(obs[1][0]), 1);
        checkOutput("nop_done_pulses", pulses, 1);

        applyStimulus(1'b0, LW, 3'b010, 7'b0000000, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_memread_enables", int'(outs & EN_MASK), 0);
        checkOutput("abort_memread_adrsrc", int'(outs[15]), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_refetch_irwrite", int'(outs[13]), 1);
        checkOutput("abort_refetch_regwrite", int'(outs[12]), 0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (m_step == 0) begin
                if ($urandom_range(0, 7) == 7) op_code = 7'($urandom);
                else op_code = ops[$urandom_range(0, 6)];
            end
            funct3 = 3'($urandom);
            funct7 = 7'($urandom);
            Zero   = 1'($urandom);
            reset  = ($urandom_range(0, 39) == 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have these ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- op_code  in  7  instruction opcode field
- funct3  in  3  instruction funct3 field
- funct7  in  7  instruction funct7 field
- Zero  in  1  ALU zero flag
- pc_write  out  1  program counter enable
- adr_src  out  1  memory address select: 0 = PC, 1 = result
- mem_write  out  1  data memory write enable
- IR_write  out  1  instruction/OldPC register enable
- reg_write  out  1  register file write enable
- result_src  out  2  result select: 00 ALUOut, 01 memory data, 10 ALU result
- alu_src_a  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  ALU B select: 00 rs2, 01 immediate, 10 constant 4
- imm_src  out  2  immediate type: 00 I, 01 S, 10 B, 11 J
- alu_control  out  3  ALU operation code
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
REQ-002 SHALL have no parameters.

Function
REQ-003 SHALL implement a Moore FSM with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
REQ-004 Transitions SHALL be:
- FETCH -> DECODE.
- DECODE -> MEMADR for lw 0000011 or sw 0100011.
- DECODE -> EXECUTER for 0110011; EXECUTEI for 0010011; BRANCH for 1100011; JAL for 1101111.
- DECODE -> FETCH for any other opcode (NOP).
- MEMADR -> MEMREAD for lw; MEMWRITE for sw.
- MEMREAD -> MEMWB.
- EXECUTER, EXECUTEI and JAL -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH.
REQ-005 Per-state outputs SHALL be as listed; any output not listed is 0/00:
- FETCH: IR_write=1, alu_src_b=10, alu_control=add, result_src=10, pc_write=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_control=add (precomputes branch/jump target).
- MEMADR: alu_src_a=10, alu_src_b=01, add.
- MEMREAD: adr_src=1.
- MEMWB: result_src=01, reg_write=1.
- MEMWRITE: adr_src=1, mem_write=1.
- EXECUTER: alu_src_a=10, alu_src_b=00, funct-decoded ALU op.
- EXECUTEI: alu_src_a=10, alu_src_b=01, funct-decoded ALU op.
- ALUWB: reg_write=1.
- BRANCH: alu_src_a=10, alu_src_b=00, sub.
- JAL: alu_src_a=01, alu_src_b=10, add, pc_write=1.
REQ-006 BRANCH SHALL assert pc_write = Zero XOR funct3[0] (beq/bne); other branch funct3 values SHALL be treated as beq/bne by funct3[0] alone.
REQ-007 imm_src SHALL decode combinationally from op_code in every state: sw -> 01, branch -> 10, jal -> 11, otherwise 00.
REQ-008 alu_control codes SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
REQ-009 Funct-decoded ALU op SHALL map funct3 as follows:
- 000 -> sub only if op_code[5]=1 and funct7[5]=1, else add.
- 001 sll, 010 slt, 100 xor, 101 srl, 110 or, 111 and.
- 011 -> add.
REQ-010 instr_done SHALL be 1 exactly in MEMWB, MEMWRITE, ALUWB, BRANCH, and in DECODE when the opcode is unsupported.
REQ-011 Instruction latency SHALL be: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; branch 3 cycles; unsupported 2 cycles.

Reset
REQ-012 On a clk edge with reset=1 the state SHALL become FETCH.
REQ-013 While reset=1, pc_write, mem_write, IR_write, reg_write and instr_done SHALL be forced to 0 combinationally.
REQ-014 Reset asserted mid-instruction SHALL abort the instruction with no further writes; the first FETCH after deassertion SHALL be a normal fetch.

Structure
REQ-015 A shared package control_pkg SHALL hold:
- the state enum
- opcode localparams
- alu_control codes
- result_src, alu_src_a, alu_src_b and imm_src encodings
REQ-016 ALU-op decoding SHALL live in one combinational sub-module, alu_decoder (inputs: alu_op[1:0], funct3, funct7[5], op_code[5]; output: alu_control).

Verification
REQ-017 Reset held 2 cycles, then released with op_code=0110011, funct3=000, funct7=0100000 -> states FETCH, DECODE, EXECUTER (alu_control=001), ALUWB (reg_write=1), FETCH; no enables asserted during reset.
REQ-018 op_code=0000011 -> 5-cycle sequence ending in MEMWB with result_src=01 and reg_write=1; MEMREAD has adr_src=1.
REQ-019 op_code=0100011 -> MEMWRITE with mem_write=1, adr_src=1 and imm_src=01; instr_done pulses once.
REQ-020 op_code=1100011 in BRANCH:
- funct3=000, Zero=1 -> pc_write=1.
- funct3=001, Zero=1 -> pc_write=0.
REQ-021 op_code=1101111 -> JAL has pc_write=1, alu_src_a=01, alu_src_b=10; then ALUWB with reg_write=1; imm_src=11 throughout.
REQ-022 Unsupported op_code=1111111 -> DECODE then FETCH with instr_done=1 in DECODE; reset=1 asserted in MEMREAD -> next state FETCH, reg_write never asserted.
